// File: rtl/adder_hs_pkg.sv
// Shared definitions for the adder handshake initiators: FSM encoding,
// default widths and the timeout counter width.
package adder_hs_pkg;

    localparam int DEF_ABITWIDTH = 21;
    localparam int DEF_BBITWIDTH = 21;
    localparam int DEF_SBITWIDTH = 22;
    localparam int DEF_TIMEOUT   = 15;
    localparam int TO_CNT_W      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } hs_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/adder_hs_timeout_counter.sv
// Wait-cycle counter for handshake initiators: clear, increment, and a
// terminal-count flag raised on the cycle whose increment would reach TIMEOUT.
module hs_timeout_counter
    import adder_hs_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
)(
    input  logic clock,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_tc
);

    logic [TO_CNT_W-1:0] r_count;
    logic [TO_CNT_W:0]   w_count_next;

    // One spare bit so the compare is exact even for TIMEOUT = 255.
    assign w_count_next = {1'b0, r_count} + (TO_CNT_W+1)'(1);
    assign o_tc         = (w_count_next == (TO_CNT_W+1)'(TIMEOUT));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= w_count_next[TO_CNT_W-1:0];
        end
    end

endmodule

// File: rtl/adder_handshake_requester.sv
// Initiator side of the enable/ready adder handshake with wait timeout.
// Optional sum overflow/integrity flag out_ovf under ADDER_REQ_OVF_CHECK_EN.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand pair
// ISSUE | add_enable strobe, timeout counter cleared
// WAIT  | operands held, waiting for add_ready or timeout
// OUT   | result presented under out_valid until out_ready
module adder_handshake_requester
    import adder_hs_pkg::*;
#(
    parameter int ABITWIDTH = DEF_ABITWIDTH,
    parameter int BBITWIDTH = DEF_BBITWIDTH,
    parameter int SBITWIDTH = DEF_SBITWIDTH,
    parameter int TIMEOUT   = DEF_TIMEOUT
)(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ABITWIDTH-1:0] in_a,
    input  logic [BBITWIDTH-1:0] in_b,
    output logic [ABITWIDTH-1:0] add_A,
    output logic [BBITWIDTH-1:0] add_B,
    output logic                 add_enable,
    input  logic [SBITWIDTH-1:0] add_sum,
    input  logic                 add_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SBITWIDTH-1:0] out_sum,
    output logic                 out_error
`ifdef ADDER_REQ_OVF_CHECK_EN
    ,
    output logic                 out_ovf
`endif
);

    hs_state_t r_state;
    hs_state_t w_next_state;
    logic      w_accept;
    logic      w_cap_ok;
    logic      w_cap_err;
    logic      w_cnt_clear;
    logic      w_cnt_inc;
    logic      w_tc;

    hs_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock   (clock),
        .reset_n (reset_n),
        .i_clear (w_cnt_clear),
        .i_inc   (w_cnt_inc),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_cap_ok     = 1'b0;
        w_cap_err    = 1'b0;
        w_cnt_clear  = 1'b0;
        w_cnt_inc    = 1'b0;
        in_ready     = (r_state == IDLE);
        add_enable   = (r_state == ISSUE);
        out_valid    = (r_state == OUT);
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                w_cnt_clear  = 1'b1;
                w_next_state = WAIT;
            end
            WAIT: begin
                // A ready adder beats a timeout landing on the same cycle.
                if (add_ready) begin
                    w_cap_ok     = 1'b1;
                    w_next_state = OUT;
                end else begin
                    w_cnt_inc = 1'b1;
                    if (w_tc) begin
                        w_cap_err    = 1'b1;
                        w_next_state = OUT;
                    end
                end
            end
            OUT: begin
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            add_A     <= '0;
            add_B     <= '0;
            out_sum   <= '0;
            out_error <= 1'b0;
        end else begin
            if (w_accept) begin
                add_A <= in_a;
                add_B <= in_b;
            end
            if (w_cap_ok) begin
                out_sum   <= add_sum;
                out_error <= 1'b0;
            end else if (w_cap_err) begin
                out_sum   <= '0;
                out_error <= 1'b1;
            end
        end
    end

`ifdef ADDER_REQ_OVF_CHECK_EN
    localparam int LW = max_int(ABITWIDTH, BBITWIDTH) + 1;
    localparam int CW = max_int(LW, SBITWIDTH);

    logic [CW-1:0] w_local_sum;
    logic [CW-1:0] w_sum_ext;
    logic [CW-1:0] w_smax;
    logic          w_ovf;
    logic          r_ovf;

    // Flag both a sum that cannot fit in SBITWIDTH and an adder that disagrees.
    assign w_local_sum = CW'(add_A) + CW'(add_B);
    assign w_sum_ext   = CW'(add_sum);
    assign w_smax      = CW'({SBITWIDTH{1'b1}});
    assign w_ovf       = (w_local_sum > w_smax) || (w_sum_ext != w_local_sum);
    assign out_ovf     = r_ovf;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
        end else if (w_cap_ok) begin
            r_ovf <= w_ovf;
        end else if (w_cap_err) begin
            r_ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_adder_handshake_requester.sv
// Self-checking bench for adder_handshake_requester with a behavioural adder
// and a rule-based expected-result model (ADDER_REQ_OVF_CHECK_EN aware).
module tb_adder_handshake_requester;

    localparam int AW = 21;
    localparam int BW = 21;
`ifdef ADDER_REQ_OVF_CHECK_EN
    localparam int SW = 21;
`else
    localparam int SW = 22;
`endif
    localparam int TO = 15;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_a = '0;
    logic [BW-1:0] in_b = '0;
    logic [AW-1:0] add_A;
    logic [BW-1:0] add_B;
    logic          add_enable;
    logic [SW-1:0] add_sum = '0;
    logic          add_ready = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [SW-1:0] out_sum;
    logic          out_error;
`ifdef ADDER_REQ_OVF_CHECK_EN
    logic          out_ovf;
`endif

    int checks = 0;
    int errors = 0;

    int            adder_lat = 1;
    bit            adder_dead = 1'b0;
    bit            tb_corrupt = 1'b0;
    int            cnt_left = 0;
    logic [SW-1:0] pend_sum = '0;
    logic [AW:0]   w_adder_full;
    logic [SW-1:0] w_adder_sum;

    adder_handshake_requester #(
        .ABITWIDTH (AW),
        .BBITWIDTH (BW),
        .SBITWIDTH (SW),
        .TIMEOUT   (TO)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .add_A      (add_A),
        .add_B      (add_B),
        .add_enable (add_enable),
        .add_sum    (add_sum),
        .add_ready  (add_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_error  (out_error)
`ifdef ADDER_REQ_OVF_CHECK_EN
        ,
        .out_ovf    (out_ovf)
`endif
    );

    always #5 clock = ~clock;

    // Adder environment: result and sticky ready appear adder_lat edges after enable.
    assign w_adder_full = {1'b0, add_A} + {1'b0, add_B};
    assign w_adder_sum  = SW'(w_adder_full) ^ SW'(tb_corrupt);

    always @(posedge clock) begin
        if (adder_dead) begin
            add_ready <= 1'b0;
            cnt_left  <= 0;
        end else if (add_enable) begin
            pend_sum <= w_adder_sum;
            if (adder_lat <= 1) begin
                add_sum   <= w_adder_sum;
                add_ready <= 1'b1;
                cnt_left  <= 0;
            end else begin
                add_sum   <= '0;
                add_ready <= 1'b0;
                cnt_left  <= adder_lat - 1;
            end
        end else if (cnt_left == 1) begin
            add_sum   <= pend_sum;
            add_ready <= 1'b1;
            cnt_left  <= 0;
        end else if (cnt_left > 1) begin
            cnt_left <= cnt_left - 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [SW-1:0] ref_sum(input logic [AW-1:0] a, input logic [BW-1:0] b);
        longint s;
        s = (longint'(a) + longint'(b)) % (longint'(1) << SW);
        return SW'(s);
    endfunction

    // One full transaction; expected latency follows from the adder delay vs TIMEOUT.
    task automatic run_txn(input logic [AW-1:0] a, input logic [BW-1:0] b, input int lat,
                           input bit dead, input int bp, input logic [SW-1:0] exp_sum,
                           input bit exp_err);
        int exp_lat;
        int w;
        bit exp_ovf;
        adder_lat  = lat;
        adder_dead = dead;
        exp_lat    = 2 + ((dead || lat > TO) ? TO : lat);
        exp_ovf    = !exp_err && (((longint'(a) + longint'(b)) >= (longint'(1) << SW)) || tb_corrupt);
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clock);
            w++;
        end
        check("accept_ready", 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        for (int c = 1; c <= exp_lat; c++) begin
            @(negedge clock);
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = AW'($urandom);
            in_b      = BW'($urandom);
            out_ready = (c < exp_lat) ? 1'($urandom_range(0, 1)) : 1'b0;
            check("add_enable", 64'(add_enable), 64'(c == 1));
            check("out_valid", 64'(out_valid), 64'(c == exp_lat));
            if (c == 1) begin
                check("add_A", 64'(add_A), 64'(a));
                check("add_B", 64'(add_B), 64'(b));
            end
        end
        check("out_sum", 64'(out_sum), 64'(exp_sum));
        check("out_error", 64'(out_error), 64'(exp_err));
        check("in_ready_busy", 64'(in_ready), 64'(0));
`ifdef ADDER_REQ_OVF_CHECK_EN
        check("out_ovf", 64'(out_ovf), 64'(exp_ovf));
`endif
        for (int k = 0; k < bp; k++) begin
            @(negedge clock);
            in_valid = 1'($urandom_range(0, 1));
            check("hold_valid", 64'(out_valid), 64'(1));
            check("hold_sum", 64'(out_sum), 64'(exp_sum));
            check("hold_in_ready", 64'(in_ready), 64'(0));
            check("hold_enable", 64'(add_enable), 64'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check("drain_valid", 64'(out_valid), 64'(0));
        check("drain_in_ready", 64'(in_ready), 64'(1));
    endtask

    typedef struct {
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        int            lat;
        bit            dead;
        int            bp;
        logic [22:0]   sum;
        bit            err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{a: 21'd5,        b: 21'd7,        lat: 1,  dead: 1'b0, bp: 0,  sum: 23'd12,       err: 1'b0};
        vecs[1] = '{a: 21'h1FFFFF,   b: 21'd1,        lat: 1,  dead: 1'b0, bp: 0,  sum: 23'h200000,   err: 1'b0};
        vecs[2] = '{a: 21'd3,        b: 21'd4,        lat: 1,  dead: 1'b0, bp: 0,  sum: 23'd7,        err: 1'b0};
        vecs[3] = '{a: 21'd9,        b: 21'd9,        lat: 1,  dead: 1'b1, bp: 1,  sum: 23'd0,        err: 1'b1};
        vecs[4] = '{a: 21'd100,      b: 21'd23,       lat: 1,  dead: 1'b0, bp: 10, sum: 23'd123,      err: 1'b0};
        vecs[5] = '{a: 21'd10,       b: 21'd20,       lat: 15, dead: 1'b0, bp: 0,  sum: 23'd30,       err: 1'b0};
        vecs[6] = '{a: 21'd10,       b: 21'd20,       lat: 16, dead: 1'b0, bp: 2,  sum: 23'd0,        err: 1'b1};
        vecs[7] = '{a: 21'h1FFFFF,   b: 21'h1FFFFF,   lat: 3,  dead: 1'b0, bp: 0,  sum: 23'h3FFFFE,   err: 1'b0};

        repeat (2) @(negedge clock);
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_add_enable", 64'(add_enable), 64'(0));
        check("rst_out_sum", 64'(out_sum), 64'(0));
        check("rst_out_error", 64'(out_error), 64'(0));
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].dead, vecs[i].bp,
                    SW'(vecs[i].sum), vecs[i].err);
        end

        // Reset during WAIT: everything returns to reset values immediately.
        adder_dead = 1'b1;
        in_valid = 1'b1;
        in_a = 21'd1;
        in_b = 21'd1;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("wait_busy", 64'(in_ready), 64'(0));
        reset_n = 1'b0;
        #1;
        check("arst_in_ready", 64'(in_ready), 64'(1));
        check("arst_add_A", 64'(add_A), 64'(0));
        check("arst_out_valid", 64'(out_valid), 64'(0));
        @(negedge clock);
        reset_n = 1'b1;
        adder_dead = 1'b0;
        @(negedge clock);
        run_txn(21'd2, 21'd2, 1, 1'b0, 0, SW'(4), 1'b0);

        // Reset while a result is pending in OUT: out_valid drops without a clock edge.
        adder_lat = 1;
        in_valid = 1'b1;
        in_a = 21'd40;
        in_b = 21'd2;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        check("pre_rst_valid", 64'(out_valid), 64'(1));
        check("pre_rst_sum", 64'(out_sum), 64'(42));
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_out_valid_out", 64'(out_valid), 64'(0));
        check("arst_out_sum", 64'(out_sum), 64'(0));
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

`ifdef ADDER_REQ_OVF_CHECK_EN
        run_txn(21'h1FFFFF, 21'd1, 1, 1'b0, 0, SW'(0), 1'b0);
        run_txn(21'd1, 21'd1, 1, 1'b0, 0, SW'(2), 1'b0);
        tb_corrupt = 1'b1;
        run_txn(21'd1, 21'd1, 1, 1'b0, 0, SW'(3), 1'b0);
        tb_corrupt = 1'b0;
`endif

        for (int n = 0; n < 30; n++) begin
            logic [AW-1:0] ra;
            logic [BW-1:0] rb;
            int            rl;
            bit            rd;
            bit            rerr;
            ra   = ($urandom_range(0, 4) == 0) ? {AW{1'b1}} : AW'($urandom);
            rb   = BW'($urandom);
            rl   = $urandom_range(1, 18);
            rd   = ($urandom_range(0, 9) == 0);
            rerr = rd || (rl > TO);
            run_txn(ra, rb, rl, rd, $urandom_range(0, 3),
                    rerr ? SW'(0) : ref_sum(ra, rb), rerr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
